// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern source: raster-ordered {8'h00,B,G,R} pixels with
// tuser on the first pixel of a frame and tlast on the last pixel of a line.
//
// state    | meaning
// S_IDLE   | no stream; waits for enable_i, then loads pixel (0,0)
// S_STREAM | tvalid held high; pixels advance on each accepted transfer
module video_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CHK_LOG2 = 5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic [1:0]  mode_i,
   input  logic [23:0] color_i,
   input  logic        m_axis_tready,
   output logic        m_axis_tvalid,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [15:0] frame_count_o,
   output logic        busy_o
);

   localparam int XW    = $clog2(H_ACTIVE);
   localparam int YW    = $clog2(V_ACTIVE);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int YE_W  = (CHK_LOG2 >= 8) ? CHK_LOG2 + 1 : 8;

   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   function automatic logic [23:0] pixel_f(
      input logic [XW-1:0] x,
      input logic [YW-1:0] y,
      input logic [1:0]    mode,
      input logic [23:0]   color
   );
      logic [15:0]     xe;
      logic [YE_W-1:0] ye;
      logic [7:0]      sum;
      logic [2:0]      bar;
      xe  = 16'(x);
      ye  = YE_W'(y);
      sum = xe[7:0] + ye[7:0];
      bar = 3'(xe / 16'(BAR_W));
      pixel_f = 24'h0;
      case (mode)
         2'd0: begin
            case (bar)
               3'd0:    pixel_f = 24'hFFFFFF;
               3'd1:    pixel_f = 24'h00FFFF;
               3'd2:    pixel_f = 24'hFFFF00;
               3'd3:    pixel_f = 24'h00FF00;
               3'd4:    pixel_f = 24'hFF00FF;
               3'd5:    pixel_f = 24'h0000FF;
               3'd6:    pixel_f = 24'hFF0000;
               default: pixel_f = 24'h000000;
            endcase
         end
         2'd1:    pixel_f = {sum, ye[7:0], xe[7:0]};
         2'd2:    pixel_f = (xe[CHK_LOG2] ^ ye[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
         default: pixel_f = color;
      endcase
   endfunction

   logic [0:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    mode_q, mode_d;
   logic [23:0]   color_q, color_d;
   logic [23:0]   pix_q, pix_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic          tuser_q, tuser_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   logic          transfer;
   logic          x_last;
   logic          y_last;
   logic          frame_end;
   logic [XW-1:0] x_nxt;
   logic [YW-1:0] y_nxt;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [1:0]    pix_mode;
   logic [23:0]   pix_color;
   logic [23:0]   pix_nxt;

   always_comb begin
      transfer  = tvalid_q & m_axis_tready;
      x_last    = (x_q == X_LAST);
      y_last    = (y_q == Y_LAST);
      frame_end = transfer & x_last & y_last;
      x_nxt     = x_last ? '0 : x_q + 1'b1;
      y_nxt     = x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;

      // Frame start uses the freshly sampled mode/colour, not the latched copy.
      if ((state_q == S_IDLE) || frame_end) begin
         pix_x     = '0;
         pix_y     = '0;
         pix_mode  = mode_i;
         pix_color = color_i;
      end else begin
         pix_x     = x_nxt;
         pix_y     = y_nxt;
         pix_mode  = mode_q;
         pix_color = color_q;
      end
      pix_nxt = pixel_f(pix_x, pix_y, pix_mode, pix_color);

      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      mode_d      = mode_q;
      color_d     = color_q;
      pix_d       = pix_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      tuser_d     = tuser_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (enable_i) begin
               mode_d   = mode_i;
               color_d  = color_i;
               x_d      = '0;
               y_d      = '0;
               pix_d    = pix_nxt;
               tlast_d  = 1'b0;
               tuser_d  = 1'b1;
               tvalid_d = 1'b1;
               state_d  = S_STREAM;
            end
         end
         default: begin
            if (transfer) begin
               x_d = x_nxt;
               y_d = y_nxt;
               if (frame_end) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  mode_d      = mode_i;
                  color_d     = color_i;
                  if (enable_i) begin
                     pix_d   = pix_nxt;
                     tlast_d = 1'b0;
                     tuser_d = 1'b1;
                  end else begin
                     pix_d    = 24'h0;
                     tlast_d  = 1'b0;
                     tuser_d  = 1'b0;
                     tvalid_d = 1'b0;
                     state_d  = S_IDLE;
                  end
               end else begin
                  pix_d   = pix_nxt;
                  tlast_d = (x_nxt == X_LAST);
                  tuser_d = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= 2'd0;
         color_q     <= 24'h0;
         pix_q       <= 24'h0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
         frame_cnt_q <= 16'h0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         mode_q      <= mode_d;
         color_q     <= color_d;
         pix_q       <= pix_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         tuser_q     <= tuser_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = {8'h00, pix_q};
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign frame_count_o = frame_cnt_q;
   assign busy_o        = (state_q == S_STREAM);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with a 16x4 raster: captured transfers
// are checked against a hand-computed vector table and a small pixel model.
module tb_video_pattern_gen;

   localparam int H = 16;
   localparam int V = 4;
   localparam int C = 1;

   localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                          24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        enable_i;
   logic [1:0]  mode_i;
   logic [23:0] color_i;
   logic        m_axis_tready;
   logic        m_axis_tvalid;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [15:0] frame_count_o;
   logic        busy_o;

   video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .CHK_LOG2(C)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .mode_i        (mode_i),
      .color_i       (color_i),
      .m_axis_tready (m_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_count_o (frame_count_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        last;
      logic        user;
   } vec_t;

   vec_t        vecs [22];
   logic [31:0] cap_data [512];
   logic        cap_last [512];
   logic        cap_user [512];
   int          wp = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_pix(input int x, input int y, input int mode,
                                           input logic [23:0] col);
      case (mode)
         0:       return {8'h00, BARS[(x * 8) / H]};
         1:       return {8'h00, 8'((x + y) % 256), 8'(y % 256), 8'(x % 256)};
         2:       return ((((x >> C) ^ (y >> C)) & 1) != 0) ? 32'h00FFFFFF : 32'h0;
         default: return {8'h00, col};
      endcase
   endfunction

   // Runs until n transfers are captured; optional mode change / enable drop at a transfer index.
   task automatic stream(input int n, input bit rnd, input int chg_idx,
                         input logic [1:0] chg_mode, input int drop_idx);
      int          got;
      int          cyc;
      logic        hold;
      logic [34:0] held;
      logic        rdy;
      got  = 0;
      cyc  = 0;
      hold = 1'b0;
      held = '0;
      while (got < n && cyc < 4000) begin
         if (got == chg_idx) mode_i = chg_mode;
         if (got == drop_idx) enable_i = 1'b0;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axis_tready = rdy;
         if (hold)
            chk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, held);
         if (m_axis_tvalid && rdy) begin
            cap_data[wp] = m_axis_tdata;
            cap_last[wp] = m_axis_tlast;
            cap_user[wp] = m_axis_tuser;
            wp++;
            got++;
            hold = 1'b0;
         end else begin
            hold = m_axis_tvalid;
            held = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      m_axis_tready = 1'b0;
      if (got < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL stream_timeout: got %0d transfers, required %0d", got, n);
      end
   endtask

   task automatic check_model(input int base, input int n, input int mode, input logic [23:0] col);
      for (int i = 0; i < n; i++) begin
         int x;
         int y;
         x = i % H;
         y = (i / H) % V;
         chk($sformatf("model_%0d", base + i),
             {cap_data[base + i], cap_last[base + i], cap_user[base + i]},
             {exp_pix(x, y, mode, col), 1'(x == H - 1), 1'(x == 0 && y == 0)});
      end
   endtask

   initial begin
      vecs[0]  = '{0,   32'h00000000, 1'b0, 1'b1};
      vecs[1]  = '{15,  32'h000F000F, 1'b1, 1'b0};
      vecs[2]  = '{16,  32'h00010100, 1'b0, 1'b0};
      vecs[3]  = '{17,  32'h00020101, 1'b0, 1'b0};
      vecs[4]  = '{31,  32'h0010010F, 1'b1, 1'b0};
      vecs[5]  = '{47,  32'h0011020F, 1'b1, 1'b0};
      vecs[6]  = '{63,  32'h0012030F, 1'b1, 1'b0};
      vecs[7]  = '{64,  32'h00FFFFFF, 1'b0, 1'b1};
      vecs[8]  = '{65,  32'h00FFFFFF, 1'b0, 1'b0};
      vecs[9]  = '{66,  32'h0000FFFF, 1'b0, 1'b0};
      vecs[10] = '{67,  32'h0000FFFF, 1'b0, 1'b0};
      vecs[11] = '{78,  32'h00000000, 1'b0, 1'b0};
      vecs[12] = '{79,  32'h00000000, 1'b1, 1'b0};
      vecs[13] = '{85,  32'h00FFFF00, 1'b0, 1'b0};
      vecs[14] = '{149, 32'h00123456, 1'b0, 1'b0};
      vecs[15] = '{191, 32'h00123456, 1'b1, 1'b0};
      vecs[16] = '{192, 32'h00000000, 1'b0, 1'b1};
      vecs[17] = '{194, 32'h00FFFFFF, 1'b0, 1'b0};
      vecs[18] = '{226, 32'h00000000, 1'b0, 1'b0};
      vecs[19] = '{255, 32'h00000000, 1'b1, 1'b0};
      vecs[20] = '{256, 32'h00000000, 1'b0, 1'b1};
      vecs[21] = '{296, 32'h00000000, 1'b0, 1'b1};

      rst_ni        = 1'b0;
      enable_i      = 1'b0;
      mode_i        = 2'd0;
      color_i       = 24'h0;
      m_axis_tready = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
      chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
      chk("rst_tuser",  64'(m_axis_tuser),  64'd0);
      chk("rst_fcount", 64'(frame_count_o), 64'd0);
      chk("rst_busy",   64'(busy_o),        64'd0);
      rst_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("idle_busy",   64'(busy_o),        64'd0);

      // Ramp frame; mode switch to bars mid-frame must wait for the boundary.
      mode_i   = 2'd1;
      enable_i = 1'b1;
      stream(64, 1'b0, 40, 2'd0, -1);
      chk("f1_fcount", 64'(frame_count_o), 64'd1);
      chk("f1_next",   {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 1'b1, 32'h00FFFFFF});
      chk("f1_busy",   64'(busy_o), 64'd1);

      // Colour bars under random backpressure.
      color_i = 24'h123456;
      stream(64, 1'b1, 10, 2'd3, -1);
      chk("f2_fcount", 64'(frame_count_o), 64'd2);
      chk("f2_next",   {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 1'b1, 32'h00123456});

      // Solid frame; switch to checkerboard at transfer 20.
      stream(64, 1'b0, 20, 2'd2, -1);
      chk("f3_fcount", 64'(frame_count_o), 64'd3);
      chk("f3_next",   {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 1'b1, 32'h00000000});

      // Checkerboard frame with enable dropped at transfer 30.
      stream(64, 1'b0, -1, 2'd0, 30);
      chk("f4_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("f4_busy",   64'(busy_o),        64'd0);
      chk("f4_fcount", 64'(frame_count_o), 64'd4);
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      m_axis_tready = 1'b0;
      chk("f4_stays_idle", {m_axis_tvalid, busy_o}, 2'b00);

      // Reset in the middle of a frame, then restart.
      mode_i   = 2'd1;
      enable_i = 1'b1;
      stream(40, 1'b0, -1, 2'd0, -1);
      chk("mid_busy", 64'(busy_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("arst_tdata",  64'(m_axis_tdata),  64'd0);
      chk("arst_flags",  {m_axis_tlast, m_axis_tuser}, 2'b00);
      chk("arst_fcount", 64'(frame_count_o), 64'd0);
      chk("arst_busy",   64'(busy_o),        64'd0);
      #20;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      stream(1, 1'b0, -1, 2'd0, -1);
      chk("post_rst_fcount", 64'(frame_count_o), 64'd0);

      check_model(0,   64, 1, 24'h0);
      check_model(64,  64, 0, 24'h0);
      check_model(128, 64, 3, 24'h123456);
      check_model(192, 64, 2, 24'h0);
      check_model(256, 40, 1, 24'h0);
      check_model(296, 1,  1, 24'h0);

      for (int k = 0; k < 22; k++) begin
         chk($sformatf("vec_%0d", vecs[k].idx),
             {cap_data[vecs[k].idx], cap_last[vecs[k].idx], cap_user[vecs[k].idx]},
             {vecs[k].data, vecs[k].last, vecs[k].user});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
AXI4-Stream video source feeding the VGA output stage's slave stream port. It produces raster-ordered pixels, one per transfer, as 32-bit words {8'h00, B, G, R}. tuser marks the first pixel of each frame and tlast marks the last pixel of each line. The block is used for bring-up and as a fallback source when no camera or frame buffer is present. Pattern mode is selectable at frame granularity.

Parameters:
H_ACTIVE, 640, active pixels per line (>=8, multiple of 8)
V_ACTIVE, 480, active lines per frame (>=2)
CHK_LOG2, 5, checkerboard square size = 2**CHK_LOG2 pixels

Ports:
clk_i  in  1  pixel-domain clock (same clock as the VGA stage's video clock)
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  run request; sampled at frame boundaries
mode_i  in  2  0=colour bars, 1=ramp, 2=checkerboard, 3=solid
color_i  in  24  solid colour {B,G,R}, used in mode 3
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  pixel valid
m_axis_tdata  out  32  {8'h00, B[7:0], G[7:0], R[7:0]}
m_axis_tlast  out  1  last pixel of line
m_axis_tuser  out  1  first pixel of frame
frame_count_o  out  16  completed frames, wraps modulo 2**16
busy_o  out  1  high in STREAM state

Behaviour:
- Reset (async assert, sync release): state=IDLE; x=0, y=0; all outputs 0, including tvalid, tdata, tlast, tuser, frame_count_o and busy_o.
- States:
  - IDLE: if enable_i=1, latch mode_i/color_i into mode_q/color_q, load the output registers with pixel (0,0), raise tvalid next cycle, go to STREAM.
  - STREAM: tvalid=1 continuously. No bubbles within or between frames while enable_i stays high.
- Handshake: a transfer occurs when tvalid & tready.
  - While tvalid=1 & tready=0: tdata, tlast and tuser stay stable (AXI rule).
  - tvalid never drops except after the last pixel of a frame.
- Counters: on each transfer, x advances. At x=H_ACTIVE-1, x wraps to 0 and y increments. At y=V_ACTIVE-1 and x=H_ACTIVE-1, y wraps to 0.
- Output registers: on each transfer, load the pixel for the next coordinates in the same cycle. Output latency is zero bubbles; data is always registered.
- Flags:
  - tlast = (x==H_ACTIVE-1).
  - tuser = (x==0 && y==0).
- Frame end (transfer of pixel (H_ACTIVE-1, V_ACTIVE-1)):
  - frame_count_o increments; 16'hFFFF wraps to 0.
  - Re-latch mode_i and color_i.
  - If enable_i=1, continue: the next pixel is (0,0) with tuser=1.
  - If enable_i=0, go to IDLE; tvalid=0 next cycle.
  - Deasserting enable_i mid-frame does not truncate the frame.
- Mode changes mid-frame are ignored until the next frame boundary.
- Pixel functions of (x,y):
  - Mode 0, colour bars: bar = x / (H_ACTIVE/8). Bars 0..7 are white FFFFFF, yellow (R=FF,G=FF,B=0), cyan (G=FF,B=FF), green, magenta, red, blue, black.
  - Mode 1, ramp: R=x[7:0], G=y[7:0], B=(x+y)[7:0], with 8-bit truncation.
  - Mode 2, checkerboard: white if x[CHK_LOG2]^y[CHK_LOG2], else black.
  - Mode 3, solid: {B,G,R} = color_q.
- Counter widths are $clog2 of H_ACTIVE and V_ACTIVE. No other arithmetic overflow is possible.
- Reset mid-frame: immediate return to the reset state. The downstream stage resynchronises on the next tuser.

Test Plan (H_ACTIVE=16, V_ACTIVE=4, CHK_LOG2=1 unless stated):
- Reset with enable_i=0 for 10 cycles -> tvalid=0, tdata=0, frame_count_o=0, busy_o=0.
- enable_i=1, mode 1, tready=1 for 64 cycles -> 64 transfers.
  - Transfer 0: tuser=1, tdata=32'h00000000.
  - Transfer 17 (x=1,y=1): tdata=32'h00020101.
  - tlast on transfers 15, 31, 47, 63.
  - frame_count_o=1 after transfer 63; the next pixel has tuser=1.
- Mode 0, random tready (50%) -> tdata held stable whenever tvalid & !tready.
  - Pixels x=0..1 are 00FFFFFF, x=2..3 are 0000FFFF, x=14..15 are 00000000.
  - Total transfers per frame = 64.
- Mode 3 with color_i=24'h123456; switch mode_i to 2 at transfer 20 -> rest of frame 1 stays 00123456. Frame 2 is checkerboard: (0,0)=00000000, (2,0)=00FFFFFF, (2,2)=00000000.
- enable_i dropped at transfer 30 -> transfers continue to 63, then tvalid=0, busy_o=0, frame_count_o=1.
- rst_ni pulsed low at transfer 40 -> outputs 0 asynchronously. After release with enable_i=1, the first transfer is (0,0) with tuser=1 and frame_count_o=0.
